riscv_retire_trace: RTL



---
 rtl/riscv_retire_trace.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/riscv_retire_trace.sv
// Retirement trace buffer: stamps each retired instruction with a sequence
// number, normalises unused fields, and queues it in a circular FIFO drained
// over a valid/ready stream. Overflow drops records and counts them, so the
// upstream core is never stalled.
module riscv_retire_trace #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned Depth = 16
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        clear_i,
    input  logic                        retire_valid_i,
    input  logic [XLEN-1:0]             pc_i,
    input  logic [31:0]                 instr_i,
    input  logic [4:0]                  reg_addr_i,
    input  logic [XLEN-1:0]             reg_data_i,
    input  logic [XLEN-1:0]             mem_addr_i,
    input  logic [XLEN-1:0]             mem_data_i,
    input  logic                        mem_wrt_i,
    output logic                        trace_valid_o,
    input  logic                        trace_ready_i,
    output logic [31:0]                 trace_seq_o,
    output logic [XLEN-1:0]             trace_pc_o,
    output logic [31:0]                 trace_instr_o,
    output logic [4:0]                  trace_rd_o,
    output logic [XLEN-1:0]             trace_rd_data_o,
    output logic [XLEN-1:0]             trace_mem_addr_o,
    output logic [XLEN-1:0]             trace_mem_data_o,
    output logic                        trace_mem_wrt_o,
    output logic [$clog2(Depth):0]      count_o,
    output logic                        overflow_o,
    output logic [15:0]                 drop_cnt_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0]     seq;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd_data;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
        logic            mem_wrt;
    } rec_t;

    rec_t            r_mem [Depth];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_seq;
    logic            r_overflow;
    logic [15:0]     r_drop_cnt;

    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_store;
    logic            w_drop;
    rec_t            w_rec;
    rec_t            w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(Depth));
    assign w_push  = retire_valid_i & ~clear_i;
    assign w_pop   = ~w_empty & trace_ready_i & ~clear_i;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign w_store = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    // Build the normalised record: unused write-back / store fields read as zero.
    always_comb begin
        w_rec          = '0;
        w_rec.seq      = r_seq;
        w_rec.pc       = pc_i;
        w_rec.instr    = instr_i;
        w_rec.mem_wrt  = mem_wrt_i;
        if (reg_addr_i != 5'd0) begin
            w_rec.rd      = reg_addr_i;
            w_rec.rd_data = reg_data_i;
        end
        if (mem_wrt_i) begin
            w_rec.mem_addr = mem_addr_i;
            w_rec.mem_data = mem_data_i;
        end
    end

    // Pointer, occupancy, sequence and drop bookkeeping.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_seq      <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_seq      <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push) begin
                r_seq <= r_seq + 32'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end
    end

    // Record storage; contents are only observable once counted in r_count.
    always_ff @(posedge clk_i) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    assign w_head = w_empty ? rec_t'('0) : r_mem[r_rd_ptr];

    assign trace_valid_o    = ~w_empty;
    assign trace_seq_o      = w_head.seq;
    assign trace_pc_o       = w_head.pc;
    assign trace_instr_o    = w_head.instr;
    assign trace_rd_o       = w_head.rd;
    assign trace_rd_data_o  = w_head.rd_data;
    assign trace_mem_addr_o = w_head.mem_addr;
    assign trace_mem_data_o = w_head.mem_data;
    assign trace_mem_wrt_o  = w_head.mem_wrt;
    assign count_o          = r_count;
    assign overflow_o       = r_overflow;
    assign drop_cnt_o       = r_drop_cnt;

endmodule
